frame_dump_ctrl: RTL and testbench

//  Serial frame-dump sequencer. Sits downstream of the downsample buffer and upstream of the UART.
//  A debounced button press starts one dump: it rasters read_x/read_y over the buffer and forwards

---
 rtl/frame_dump_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_frame_dump_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dump_ctrl.sv
// Frame-dump sequencer: a debounced button press rasters the downsample buffer out to the UART.
// Optional macro FRAME_DUMP_HEADER_EN prepends a 4-byte header (A5, 5A, WIDTH, HEIGHT) to each dump.
module frame_dump_ctrl #(
    parameter int unsigned WIDTH         = 40,
    parameter int unsigned HEIGHT        = 30,
    parameter int unsigned X_BITS        = 6,
    parameter int unsigned Y_BITS        = 5,
    parameter int unsigned DEBOUNCE_BITS = 14,
    parameter int unsigned HOLDOFF_BITS  = 13
) (
    input  logic              clk12,
    input  logic              areset_n,
    input  logic              btn,
    output logic [X_BITS-1:0] read_x,
    output logic [Y_BITS-1:0] read_y,
    input  logic [7:0]        read_data,
    input  logic              uart_busy,
    output logic              uart_wr,
    output logic [7:0]        uart_dat,
    output logic              dump_active,
    output logic              frame_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
`ifdef FRAME_DUMP_HEADER_EN
    localparam logic [1:0] ST_HEADER = 2'd3;
`endif

    localparam logic [X_BITS-1:0]        X_LAST   = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0]        Y_LAST   = Y_BITS'(HEIGHT - 1);
    localparam logic [DEBOUNCE_BITS-1:0] DEB_MAX  = '1;
    localparam logic [HOLDOFF_BITS-1:0]  HOLD_MAX = '1;

    logic [1:0]               state_q, state_d;
    logic                     btn_meta_q, btn_meta_d;
    logic                     btn_s_q, btn_s_d;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
    logic [HOLDOFF_BITS-1:0]  hold_cnt_q, hold_cnt_d;
    logic [X_BITS-1:0]        read_x_q, read_x_d;
    logic [Y_BITS-1:0]        read_y_q, read_y_d;
    logic                     uart_wr_q, uart_wr_d;
    logic [7:0]               uart_dat_q, uart_dat_d;
    logic                     dump_active_q, dump_active_d;
    logic                     frame_done_q, frame_done_d;
`ifdef FRAME_DUMP_HEADER_EN
    logic [1:0]               hdr_cnt_q, hdr_cnt_d;
    logic [7:0]               hdr_byte_c;
`endif

    logic trigger_c;
    logic gap_ok_c;

    assign trigger_c = (state_q == ST_IDLE) && btn_s_q && (deb_cnt_q == DEB_MAX);
    assign gap_ok_c  = (hold_cnt_q == HOLD_MAX) && !uart_busy && !uart_wr_q;

`ifdef FRAME_DUMP_HEADER_EN
    always_comb begin
        hdr_byte_c = 8'hA5;
        case (hdr_cnt_q)
            2'd0:    hdr_byte_c = 8'hA5;
            2'd1:    hdr_byte_c = 8'h5A;
            2'd2:    hdr_byte_c = 8'(WIDTH);
            default: hdr_byte_c = 8'(HEIGHT);
        endcase
    end
`endif

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        read_x_d      = read_x_q;
        read_y_d      = read_y_q;
        uart_wr_d     = 1'b0;
        uart_dat_d    = uart_dat_q;
        dump_active_d = dump_active_q;
        frame_done_d  = 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
        hdr_cnt_d     = hdr_cnt_q;
`endif
        btn_meta_d = btn;
        btn_s_d    = btn_meta_q;

        // Debounce measures release time; a press only counts after a long, clean release
        if (btn_s_q)
            deb_cnt_d = '0;
        else if (deb_cnt_q == DEB_MAX)
            deb_cnt_d = deb_cnt_q;
        else
            deb_cnt_d = deb_cnt_q + DEBOUNCE_BITS'(1);

        if (uart_busy || uart_wr_q)
            hold_cnt_d = '0;
        else if (hold_cnt_q == HOLD_MAX)
            hold_cnt_d = hold_cnt_q;
        else
            hold_cnt_d = hold_cnt_q + HOLDOFF_BITS'(1);

        case (state_q)
            ST_IDLE: begin
                if (trigger_c) begin
                    read_x_d      = '0;
                    read_y_d      = '0;
                    dump_active_d = 1'b1;
`ifdef FRAME_DUMP_HEADER_EN
                    hdr_cnt_d     = 2'd0;
                    state_d       = ST_HEADER;
`else
                    state_d       = ST_FETCH;
`endif
                end
            end
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                if (gap_ok_c) begin
                    uart_dat_d = read_data;
                    uart_wr_d  = 1'b1;
                    state_d    = ST_FETCH;
                    if (read_x_q == X_LAST) begin
                        read_x_d = '0;
                        if (read_y_q == Y_LAST) begin
                            read_y_d      = '0;
                            frame_done_d  = 1'b1;
                            dump_active_d = 1'b0;
                            state_d       = ST_IDLE;
                        end else begin
                            read_y_d = read_y_q + Y_BITS'(1);
                        end
                    end else begin
                        read_x_d = read_x_q + X_BITS'(1);
                    end
                end
            end
`ifdef FRAME_DUMP_HEADER_EN
            ST_HEADER: begin
                if (gap_ok_c) begin
                    uart_dat_d = hdr_byte_c;
                    uart_wr_d  = 1'b1;
                    hdr_cnt_d  = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3)
                        state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk12 or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= ST_IDLE;
            btn_meta_q    <= 1'b0;
            btn_s_q       <= 1'b0;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            read_x_q      <= '0;
            read_y_q      <= '0;
            uart_wr_q     <= 1'b0;
            uart_dat_q    <= 8'h00;
            dump_active_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_cnt_q     <= 2'd0;
`endif
        end else begin
            state_q       <= state_d;
            btn_meta_q    <= btn_meta_d;
            btn_s_q       <= btn_s_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            read_x_q      <= read_x_d;
            read_y_q      <= read_y_d;
            uart_wr_q     <= uart_wr_d;
            uart_dat_q    <= uart_dat_d;
            dump_active_q <= dump_active_d;
            frame_done_q  <= frame_done_d;
`ifdef FRAME_DUMP_HEADER_EN
            hdr_cnt_q     <= hdr_cnt_d;
`endif
        end
    end

    assign read_x      = read_x_q;
    assign read_y      = read_y_q;
    assign uart_wr     = uart_wr_q;
    assign uart_dat    = uart_dat_q;
    assign dump_active = dump_active_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: small frame, randomized UART busy and button bounce,
// every strobed byte checked against an expected raster queue built from the frame geometry.
module tb_frame_dump_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned XB = 3;
    localparam int unsigned YB = 2;
    localparam int unsigned DB = 3;
    localparam int unsigned HB = 2;
`ifdef FRAME_DUMP_HEADER_EN
    localparam int unsigned NB = W * H + 4;
`else
    localparam int unsigned NB = W * H;
`endif

    logic          clk12     = 1'b0;
    logic          areset_n  = 1'b0;
    logic          btn       = 1'b0;
    logic          uart_busy = 1'b0;
    logic [7:0]    read_data = 8'h00;
    logic [XB-1:0] read_x;
    logic [YB-1:0] read_y;
    logic          uart_wr;
    logic [7:0]    uart_dat;
    logic          dump_active;
    logic          frame_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wr_cyc = -1000;
    int last_busy_cyc = -1000;
    int dump_strobes = 0;
    int busy_at = -1;
    int busy_len = 0;
    int busy_rand_max = 0;
    int busy_left = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    frame_dump_ctrl #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB),
        .DEBOUNCE_BITS(DB), .HOLDOFF_BITS(HB)
    ) dut (
        .clk12(clk12), .areset_n(areset_n), .btn(btn),
        .read_x(read_x), .read_y(read_y), .read_data(read_data),
        .uart_busy(uart_busy), .uart_wr(uart_wr), .uart_dat(uart_dat),
        .dump_active(dump_active), .frame_done(frame_done)
    );

    always #5 clk12 = ~clk12;

    // Buffer model: one-cycle read latency, pixel value is {y, x} in nibbles
    always @(posedge clk12) read_data <= {4'(read_y), 4'(read_x)};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Strobe monitor and UART busy responder
    always @(negedge clk12) begin
        cyc++;
        if (areset_n) begin
            if (uart_wr) begin
                dump_strobes++;
                check("wr_while_busy", 32'(uart_busy), 32'(0));
                check("wr_spacing", 32'((cyc - last_wr_cyc) >= 4), 32'(1));
                check("busy_spacing", 32'((cyc - last_busy_cyc) >= 4), 32'(1));
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_strobe", 32'(1), 32'(0));
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("uart_dat", 32'(uart_dat), 32'(exp_byte));
                    check("frame_done", 32'(frame_done), 32'(exp_q.size() == 0));
                    check("dump_active_at_wr", 32'(dump_active), 32'(exp_q.size() != 0));
                end
                busy_left = (dump_strobes == busy_at) ? busy_len
                                                      : int'($urandom_range(busy_rand_max, 0));
            end else if (frame_done) begin
                check("frame_done_stray", 32'(frame_done), 32'(0));
            end
        end
        if (uart_busy) last_busy_cyc = cyc;
        uart_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk12);
            #1;
        end
    endtask

    task automatic fill_expected();
        exp_q.delete();
`ifdef FRAME_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(W));
        exp_q.push_back(8'(H));
`endif
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++)
                exp_q.push_back(8'(y * 16 + x));
    endtask

    task automatic start_dump(input int rel);
        int k;
        btn = 1'b0;
        tick(rel);
        fill_expected();
        dump_strobes = 0;
        btn = 1'b1;
        k = 0;
        while (!dump_active && k < 8) begin
            tick(1);
            k++;
        end
        check("trigger", 32'(dump_active), 32'(1));
    endtask

    task automatic finish_dump();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        check("bytes_left", 32'(exp_q.size()), 32'(0));
        tick(2);
        check("strobe_count", 32'(dump_strobes), 32'(NB));
        check("idle_active", 32'(dump_active), 32'(0));
    endtask

    task automatic expect_quiet(input string tag, input int n);
        logic seen;
        int s;
        seen = 1'b0;
        s = dump_strobes;
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen = seen | dump_active;
        end
        check(tag, 32'(seen), 32'(0));
        check({tag, "_strobes"}, 32'(dump_strobes), 32'(s));
    endtask

    initial begin
        int k;
        tick(3);
        check("rst_read_x", 32'(read_x), 32'(0));
        check("rst_read_y", 32'(read_y), 32'(0));
        check("rst_uart_wr", 32'(uart_wr), 32'(0));
        check("rst_uart_dat", 32'(uart_dat), 32'(0));
        check("rst_dump_active", 32'(dump_active), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        areset_n = 1'b1;

        // Basic dump after a clean release
        start_dump(10);
        finish_dump();

        // Bounce with short release gaps must not trigger
        tick(5);
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 0);
            tick(1);
        end
        btn = 1'b0;
        tick(3);
        btn = 1'b1;
        expect_quiet("bounce_no_trigger", 15);
        start_dump(10);
        finish_dump();

        // Long UART busy after the third strobe
        busy_at = 3;
        busy_len = 50;
        start_dump(12);
        finish_dump();
        busy_at = -1;

        // Second press mid-dump is ignored; held button gives no new dump
        start_dump(10);
        tick(20);
        btn = 1'b0;
        tick(12);
        btn = 1'b1;
        finish_dump();
        expect_quiet("held_no_retrigger", 20);

        // Reset mid-dump aborts immediately
        start_dump(10);
        k = 0;
        while (dump_strobes < 5 && k < 1000) begin
            tick(1);
            k++;
        end
        check("reached_5_strobes", 32'(dump_strobes), 32'(5));
        #2 areset_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_uart_wr", 32'(uart_wr), 32'(0));
        check("abort_read_x", 32'(read_x), 32'(0));
        check("abort_read_y", 32'(read_y), 32'(0));
        check("abort_dump_active", 32'(dump_active), 32'(0));
        btn = 1'b0;
        tick(3);
        areset_n = 1'b1;
        expect_quiet("post_reset_quiet", 30);
        start_dump(1);
        finish_dump();

        // Randomized busy lengths and pre-press bounce
        for (int r = 0; r < 4; r++) begin
            busy_rand_max = int'($urandom_range(12, 0));
            for (int i = 0; i < int'($urandom_range(10, 0)); i++) begin
                btn = (i % 4 == 0) ? 1'b1 : 1'($urandom_range(1, 0));
                tick(1);
            end
            start_dump(10 + int'($urandom_range(5, 0)));
            finish_dump();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_chk - n_fail, n_chk);
        $fatal(1);
    end

endmodule
